// File: rtl/pipe_ctrl_pkg.sv
// Shared control constants, bus types and state encoding for the pipeline controller.
package pipe_ctrl_pkg;
  localparam logic        RstEnable   = 1'b0;
  localparam logic        JumpEnable  = 1'b1;
  localparam logic        HoldEnable  = 1'b1;
  localparam logic [31:0] InstAddrNop = 32'h0;

  localparam int FlushCycW = 4;
  typedef logic [FlushCycW-1:0] FlushCycBus;

  // Level field width for the default 3-stage front end.
  localparam int HoldLvlW = 2;
  typedef logic [HoldLvlW-1:0] HoldLvlBus;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } CtrlState;
endpackage

// File: rtl/pipe_ctrl_hold_merge.sv
// Merges per-source hold levels into a per-stage hold vector (thermometer OR).
module pipe_ctrl_hold_merge
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int NSRC   = 2,
  parameter int LVL_W  = 2
) (
  input  logic [NSRC-1:0]       i_req,
  input  logic [NSRC*LVL_W-1:0] i_lvl,
  output logic [STAGES-1:0]     o_hold
);
  // A source at level L stalls stages 0..L-1; levels beyond STAGES saturate.
  always_comb begin
    int sat;
    sat    = 0;
    o_hold = '0;
    for (int i = 0; i < NSRC; i++) begin
      sat = int'(i_lvl[i*LVL_W +: LVL_W]);
      if (sat > STAGES) sat = STAGES;
      for (int s = 0; s < STAGES; s++) begin
        if (i_req[i] && (s < sat)) o_hold[s] = HoldEnable;
      end
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// Front-end pipeline controller: merged holds, zero-latency jumps, parked jumps
// while the PC stage is frozen, and a configurable post-jump flush window.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int STAGES    = 3,
  parameter int NSRC      = 2,
  parameter int FLUSH_CYC = 1,
  parameter int LVL_W     = $clog2(STAGES+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC-1:0]         hold_req,
  input  logic [NSRC*LVL_W-1:0]   hold_lvl,
  input  logic                    jump_req,
  input  logic [ADDR_W-1:0]       jump_addr,
  output logic [STAGES-1:0]       hold_vec,
  output logic [STAGES-1:0]       flush_vec,
  output logic                    pc_jump_flag,
  output logic [ADDR_W-1:0]       pc_jump_addr,
  output logic                    jump_pending
);
  localparam FlushCycBus       FcLoad   = FlushCycBus'(FLUSH_CYC);
  localparam logic             HasFlush = (FLUSH_CYC > 0);
  localparam logic [ADDR_W-1:0] AddrNop = ADDR_W'(InstAddrNop);

  CtrlState          r_state, w_state_nxt;
  FlushCycBus        r_cnt, w_cnt_nxt;
  logic              r_pend, w_pend_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;

  logic [STAGES-1:0] w_hold;
  logic              w_frozen;
  logic              w_flag;
  logic              w_flush;
  logic [ADDR_W-1:0] w_jaddr;
  logic              w_in_rst;

  pipe_ctrl_hold_merge #(
    .STAGES(STAGES),
    .NSRC  (NSRC),
    .LVL_W (LVL_W)
  ) u_merge (
    .i_req (hold_req),
    .i_lvl (hold_lvl),
    .o_hold(w_hold)
  );

  assign w_frozen = w_hold[0];

  // Next state and the combinational jump/flush controls.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_addr_nxt  = r_addr;
    w_flag      = 1'b0;
    w_flush     = 1'b0;
    w_jaddr     = AddrNop;
    case (r_state)
      PEND: begin
        // Latest request wins; it can issue in the same cycle the PC thaws.
        w_flush    = 1'b1;
        w_jaddr    = jump_req ? jump_addr : r_addr;
        w_addr_nxt = w_jaddr;
        if (!w_frozen) begin
          w_flag     = JumpEnable;
          w_pend_nxt = 1'b0;
          if (HasFlush) begin
            w_cnt_nxt   = FcLoad;
            w_state_nxt = FLUSH;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        if (r_state == FLUSH) begin
          w_flush   = 1'b1;
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == FlushCycBus'(1)) w_state_nxt = IDLE;
        end
        // A jump in IDLE or FLUSH either issues now or parks until the PC thaws.
        if (jump_req) begin
          w_flush = 1'b1;
          if (!w_frozen) begin
            w_flag  = JumpEnable;
            w_jaddr = jump_addr;
            if (HasFlush) begin
              w_cnt_nxt   = FcLoad;
              w_state_nxt = FLUSH;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_addr_nxt  = jump_addr;
            w_pend_nxt  = 1'b1;
            w_state_nxt = PEND;
          end
        end
      end
    endcase
  end

  // State, flush counter and parked-jump registers.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_addr  <= AddrNop;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Outputs are forced quiet while reset is held, regardless of inputs.
  assign w_in_rst     = (rst == RstEnable);
  assign hold_vec     = w_in_rst ? '0 : w_hold;
  assign flush_vec    = (w_in_rst || !w_flush) ? '0 : '1;
  assign pc_jump_flag = w_in_rst ? 1'b0 : w_flag;
  assign pc_jump_addr = w_in_rst ? AddrNop : w_jaddr;
  assign jump_pending = w_in_rst ? 1'b0 : r_pend;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (FLUSH_CYC=1 and 2) share stimulus and are
// checked against a cycle-level reference model plus directed expectations.
module tb_pipe_ctrl;
  localparam int AW = 32, ST = 3, NS = 2, LW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   hold_req;
  logic [NS*LW-1:0] hold_lvl;
  logic            jump_req;
  logic [AW-1:0]   jump_addr;

  logic [ST-1:0] hv[2], fv[2];
  logic          fl[2], jp[2];
  logic [AW-1:0] pa[2];

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(AW), .STAGES(ST), .NSRC(NS), .FLUSH_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst), .hold_req(hold_req), .hold_lvl(hold_lvl),
    .jump_req(jump_req), .jump_addr(jump_addr), .hold_vec(hv[0]), .flush_vec(fv[0]),
    .pc_jump_flag(fl[0]), .pc_jump_addr(pa[0]), .jump_pending(jp[0]));

  pipe_ctrl #(.ADDR_W(AW), .STAGES(ST), .NSRC(NS), .FLUSH_CYC(2)) u_dut2 (
    .clk(clk), .rst(rst), .hold_req(hold_req), .hold_lvl(hold_lvl),
    .jump_req(jump_req), .jump_addr(jump_addr), .hold_vec(hv[1]), .flush_vec(fv[1]),
    .pc_jump_flag(fl[1]), .pc_jump_addr(pa[1]), .jump_pending(jp[1]));

  int n_tests = 0, n_fail = 0;

  // Reference model state: is a jump parked, its target, flush cycles still owed.
  bit            m_pend[2];
  logic [AW-1:0] m_addr[2];
  int            m_fl[2];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [ST-1:0] ref_hold(logic [NS-1:0] rq, logic [NS*LW-1:0] lv);
    logic [ST-1:0] h;
    h = '0;
    for (int i = 0; i < NS; i++) begin
      int l;
      l = int'(lv[i*LW +: LW]);
      if (l > ST) l = ST;
      if (rq[i]) for (int s = 0; s < l; s++) h[s] = 1'b1;
    end
    return h;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 1'b0; m_addr[d] = '0; m_fl[d] = 0;
    end
  endtask

  task automatic drv(logic [NS-1:0] rq, logic [NS*LW-1:0] lv, logic jr, logic [AW-1:0] ja);
    hold_req = rq; hold_lvl = lv; jump_req = jr; jump_addr = ja;
  endtask

  // Compare both DUTs against the model for the current inputs, then clock once.
  task automatic step(string tag);
    bit            np[2];
    logic [AW-1:0] na[2];
    int            nf[2];
    logic [ST-1:0] eh, ef;
    logic          efl, fr;
    logic [AW-1:0] ea;
    #1;
    for (int d = 0; d < 2; d++) begin
      int fc;
      fc = d + 1;
      eh = ref_hold(hold_req, hold_lvl);
      fr = eh[0];
      ef = '0; efl = 1'b0; ea = '0;
      np[d] = m_pend[d]; na[d] = m_addr[d]; nf[d] = m_fl[d];
      if (m_pend[d]) begin
        ef = '1;
        ea = jump_req ? jump_addr : m_addr[d];
        na[d] = ea;
        if (!fr) begin efl = 1'b1; np[d] = 1'b0; nf[d] = fc; end
      end else if (jump_req) begin
        ef = '1;
        if (!fr) begin efl = 1'b1; ea = jump_addr; nf[d] = fc; end
        else begin np[d] = 1'b1; na[d] = jump_addr; end
      end else if (m_fl[d] > 0) begin
        ef = '1;
        nf[d] = m_fl[d] - 1;
      end
      chk($sformatf("%s.d%0d.hold", tag, d), hv[d], eh);
      chk($sformatf("%s.d%0d.flush", tag, d), fv[d], ef);
      chk($sformatf("%s.d%0d.flag", tag, d), fl[d], efl);
      chk($sformatf("%s.d%0d.addr", tag, d), pa[d], ea);
      chk($sformatf("%s.d%0d.pend", tag, d), jp[d], m_pend[d]);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = np[d]; m_addr[d] = na[d]; m_fl[d] = nf[d];
    end
    #1;
  endtask

  typedef struct {
    logic [NS-1:0]    req;
    logic [NS*LW-1:0] lvl;
    logic [ST-1:0]    eh;
  } vec_t;

  vec_t tbl[6];

  localparam logic [NS*LW-1:0] L_S1_3_S0_3 = {2'd3, 2'd3};
  localparam logic [NS*LW-1:0] L_NONE      = {2'd0, 2'd0};

  initial begin
    tbl[0] = '{2'b11, {2'd3, 2'd1}, 3'b111};
    tbl[1] = '{2'b01, {2'd3, 2'd1}, 3'b001};
    tbl[2] = '{2'b01, {2'd3, 2'd0}, 3'b000};
    tbl[3] = '{2'b10, {2'd2, 2'd3}, 3'b011};
    tbl[4] = '{2'b11, {2'd0, 2'd0}, 3'b000};
    tbl[5] = '{2'b11, {2'd1, 2'd2}, 3'b011};

    // Reset with busy inputs: every output must read zero.
    rst = 1'b0;
    drv(2'b11, L_S1_3_S0_3, 1'b1, 32'hdead_beef);
    model_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst.d%0d.hold", d), hv[d], 3'b000);
      chk($sformatf("rst.d%0d.flush", d), fv[d], 3'b000);
      chk($sformatf("rst.d%0d.flag", d), fl[d], 1'b0);
      chk($sformatf("rst.d%0d.addr", d), pa[d], 32'h0);
      chk($sformatf("rst.d%0d.pend", d), jp[d], 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drv(2'b00, L_NONE, 1'b0, 32'h0);
    step("idle");

    // Hold merge table.
    for (int i = 0; i < 6; i++) begin
      drv(tbl[i].req, tbl[i].lvl, 1'b0, 32'h0);
      #1;
      chk($sformatf("tbl%0d.hold", i), hv[0], tbl[i].eh);
      chk($sformatf("tbl%0d.flush", i), fv[0], 3'b000);
      step($sformatf("tbl%0d", i));
    end

    // Plain jump, no holds.
    drv(2'b00, L_NONE, 1'b1, 32'h0000_0100);
    #1;
    chk("plain.n.flag", fl[0], 1'b1);
    chk("plain.n.addr", pa[0], 32'h100);
    chk("plain.n.flush", fv[0], 3'b111);
    step("plain.n");
    drv(2'b00, L_NONE, 1'b0, 32'h0);
    #1;
    chk("plain.n1.flush", fv[0], 3'b111);
    chk("plain.n1.flag", fl[0], 1'b0);
    step("plain.n1");
    #1;
    chk("plain.n2.flush", fv[0], 3'b000);
    step("plain.n2");
    step("plain.n3");

    // Parked jump: CLINT (src1) holds at level 3 for cycles 0..3.
    drv(2'b10, L_S1_3_S0_3, 1'b0, 32'h0);
    step("park.c0");
    drv(2'b10, L_S1_3_S0_3, 1'b1, 32'h0000_0200);
    #1;
    chk("park.c1.flag", fl[0], 1'b0);
    step("park.c1");
    drv(2'b10, L_S1_3_S0_3, 1'b0, 32'h0);
    #1;
    chk("park.c2.pend", jp[0], 1'b1);
    step("park.c2");
    step("park.c3");
    drv(2'b00, L_NONE, 1'b0, 32'h0);
    #1;
    chk("park.c4.flag", fl[0], 1'b1);
    chk("park.c4.addr", pa[0], 32'h200);
    step("park.c4");
    #1;
    chk("park.c5.pend", jp[0], 1'b0);
    step("park.c5");
    step("park.c6");
    step("park.c7");

    // Overwrite while parked: the release cycle issues the latest target once.
    drv(2'b10, L_S1_3_S0_3, 1'b1, 32'h0000_0200);
    step("ovw.a");
    drv(2'b10, L_S1_3_S0_3, 1'b1, 32'h0000_0300);
    step("ovw.b");
    drv(2'b10, L_S1_3_S0_3, 1'b0, 32'h0);
    #1;
    chk("ovw.c.addr", pa[0], 32'h300);
    chk("ovw.c.flag", fl[0], 1'b0);
    step("ovw.c");
    drv(2'b00, L_NONE, 1'b0, 32'h0);
    #1;
    chk("ovw.rel.flag", fl[0], 1'b1);
    chk("ovw.rel.addr", pa[0], 32'h300);
    step("ovw.rel");
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("ovw.after%0d.flag", k), fl[0], 1'b0);
      step($sformatf("ovw.after%0d", k));
    end

    // Back-to-back jumps on the FLUSH_CYC=2 instance.
    drv(2'b00, L_NONE, 1'b1, 32'h0000_0380);
    step("b2b.j1");
    drv(2'b00, L_NONE, 1'b1, 32'h0000_0400);
    #1;
    chk("b2b.j2.flag", fl[1], 1'b1);
    chk("b2b.j2.addr", pa[1], 32'h400);
    step("b2b.j2");
    drv(2'b00, L_NONE, 1'b0, 32'h0);
    #1;
    chk("b2b.f1.flush", fv[1], 3'b111);
    step("b2b.f1");
    #1;
    chk("b2b.f2.flush", fv[1], 3'b111);
    step("b2b.f2");
    #1;
    chk("b2b.f3.flush", fv[1], 3'b000);
    step("b2b.f3");

    // Async reset in the middle of PEND discards the parked jump.
    drv(2'b10, L_S1_3_S0_3, 1'b1, 32'h0000_0500);
    step("arst.park");
    drv(2'b10, L_S1_3_S0_3, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("arst.d%0d.hold", d), hv[d], 3'b000);
      chk($sformatf("arst.d%0d.flush", d), fv[d], 3'b000);
      chk($sformatf("arst.d%0d.flag", d), fl[d], 1'b0);
      chk($sformatf("arst.d%0d.addr", d), pa[d], 32'h0);
      chk($sformatf("arst.d%0d.pend", d), jp[d], 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drv(2'b00, L_NONE, 1'b0, 32'h0);
    #1;
    chk("arst.post.flag0", fl[0], 1'b0);
    chk("arst.post.flag1", fl[1], 1'b0);
    step("arst.post");
    step("arst.post2");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [NS-1:0] rq;
      for (int i = 0; i < NS; i++) rq[i] = ($urandom_range(0, 9) < 3);
      drv(rq, NS*LW'($urandom), ($urandom_range(0, 3) == 0), $urandom);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline controller that replaces the single-level combinational hold/jump logic.
- Merges NSRC hold requesters, each with its own stall depth, into a per-stage hold vector.
- Issues jumps to the PC register and flushes younger stages for a configurable number of cycles.
- Parks a jump that arrives while the PC stage is frozen, and releases it when the PC stage thaws. Sits between EX/CLINT/other requesters and the PC/IF/ID stages.

Parameters:
- ADDR_W, 32, instruction address width.
- STAGES, 3, number of front-end stages controlled; index 0 = PC, ascending toward EX.
- NSRC, 2, number of hold requesters (EX, CLINT, ...).
- FLUSH_CYC, 1, extra flush cycles after the jump-issue cycle; range 0..15.
- LVL_W, $clog2(STAGES+1), width of one hold-level field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- hold_req  in  NSRC  per-source hold request.
- hold_lvl  in  NSRC*LVL_W  per-source depth; source i with level L holds stages 0..L-1; L=0 is a null request.
- jump_req  in  1  jump request from EX.
- jump_addr  in  ADDR_W  jump target.
- hold_vec  out  STAGES  per-stage hold (stall) flags.
- flush_vec  out  STAGES  per-stage flush (bubble insert) flags.
- pc_jump_flag  out  1  load PC with pc_jump_addr this cycle.
- pc_jump_addr  out  ADDR_W  jump target to PC.
- jump_pending  out  1  a parked jump is waiting.

Behaviour:
- Reset (rst=0, async): state IDLE, flush counter 0, pending register and address 0. All outputs 0; pc_jump_addr = 0.
- Hold merge (combinational):
  - hold_vec[s] = OR over i of (hold_req[i] && s < hold_lvl[i]).
  - Levels > STAGES saturate to STAGES.
  - pc_frozen = hold_vec[0].
- State IDLE:
  - jump_req && !pc_frozen:
    - pc_jump_flag=1 and pc_jump_addr=jump_addr in the same cycle (0 latency).
    - flush_vec = all stages below EX (all ones) this cycle.
    - If FLUSH_CYC>0, counter loads FLUSH_CYC and go to FLUSH.
  - jump_req && pc_frozen:
    - Latch jump_addr, set jump_pending, go to PEND.
    - pc_jump_flag=0; flush_vec all ones this cycle to kill the wrong-path instruction.
- State PEND:
  - pc_jump_addr = latched address.
  - Flush_vec all ones every cycle in PEND.
  - On the first cycle with !pc_frozen: pc_jump_flag=1, clear pending, then go to FLUSH (FLUSH_CYC>0) or IDLE.
  - A new jump_req while in PEND overwrites the latched address; the last one wins. If pc_frozen has already dropped in that same cycle, the new address issues directly.
- State FLUSH:
  - flush_vec all ones; counter decrements each cycle; leave for IDLE when the counter reaches 1→0.
  - A jump_req in FLUSH is handled exactly as in IDLE (issue or park) and reloads the counter.
- Priority: flush overrides hold for the same stage. hold_vec is still driven so the stage keeps its PC; the stage must treat flush as a bubble.
- Reset mid-PEND or mid-FLUSH: the jump is discarded with no pc_jump_flag pulse.
- Control outputs are combinational from state plus inputs. The state, counter and pending registers update on posedge clk.

Decomposition:
- Shared defines file gains: HoldLvlBus, FlushCycBus, CtrlState encodings (IDLE/PEND/FLUSH), plus the existing RstEnable, JumpEnable and HoldEnable constants, and InstAddrNop.
- One sub-module: hold_merge (thermometer-mask OR of NSRC level requests → hold_vec), parametrised by STAGES, NSRC and LVL_W.

Test Plan:
- Hold merge: NSRC=2, src0 lvl=1, src1 lvl=3, both asserted → hold_vec=3'b111. Drop src1 → hold_vec=3'b001. lvl=0 asserted → 3'b000.
- Plain jump, FLUSH_CYC=1, jump_addr=0x0000_0100 with no holds:
  - Cycle N: pc_jump_flag=1, addr 0x100, flush_vec=3'b111.
  - Cycle N+1: flush_vec=3'b111, pc_jump_flag=0.
  - Cycle N+2: flush_vec=0.
- Parked jump:
  - CLINT holds lvl=3 for 4 cycles; jump 0x200 arrives in cycle 1 → jump_pending=1, no pc_jump_flag.
  - Hold drops in cycle 4 → pc_jump_flag=1, addr 0x200, pending clears.
- Overwrite: while pending with 0x200, a new jump 0x300 arrives → the release cycle issues 0x300 exactly once.
- Back-to-back: FLUSH_CYC=2, second jump 0x400 arrives in the first flush cycle → immediate issue and the counter reloads; flush lasts 2 cycles after the second issue.
- Async reset: assert rst=0 mid-PEND, between clock edges → all outputs 0 immediately; after release, no stale pc_jump_flag.
